// File: rtl/bp_pkg.sv
// Shared constants for the fetch-stage branch predictor: counter encodings,
// reset/allocation counter values and the sequential PC increment.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  localparam cnt_e        CNT_RESET = WNT;
  localparam cnt_e        CNT_ALLOC = WT;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating branch counter.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] next
);

  // Step toward strongly-taken or strongly-not-taken, holding at either end
  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != ST) next = cur + 2'd1;
    end else begin
      if (cur != SNT) next = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with 2-bit counters and stored targets.
// Lookup is combinational from the flop table, so a same-cycle update on the
// same index is seen only on the following cycle.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_fetch_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_next_pc,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_recover_pc,
  output logic [31:0] o_stat_branches,
  output logic [31:0] o_stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TAG_W-1:0] tag_d   [ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];
  logic [1:0]       cnt_d   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [31:0]      tgt_d   [ENTRIES];

  logic [31:0] branches_q, branches_d;
  logic [31:0] mispredicts_q, mispredicts_d;

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_cnt_next;

  assign fetch_idx = i_fetch_pc[IDX_W+1:2];
  assign fetch_tag = i_fetch_pc[31:IDX_W+2];
  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

  assign o_pred_taken = fetch_hit && cnt_q[fetch_idx][1];
  assign o_next_pc    = o_pred_taken ? tgt_q[fetch_idx] : (i_fetch_pc + PC_STEP);

  assign upd_idx = i_upd_pc[IDX_W+1:2];
  assign upd_tag = i_upd_pc[31:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign o_mispredict = i_upd_valid &&
                        ((i_upd_taken != i_upd_pred_taken) ||
                         (i_upd_taken && (i_upd_pred_target != i_upd_target)));
  assign o_recover_pc = i_upd_taken ? i_upd_target : (i_upd_pc + PC_STEP);

  assign o_stat_branches    = branches_q;
  assign o_stat_mispredicts = mispredicts_q;

  bp_sat_counter u_sat_counter (
    .cur   (cnt_q[upd_idx]),
    .taken (i_upd_taken),
    .next  (upd_cnt_next)
  );

  // Train on a hit, allocate on a taken miss, ignore a not-taken miss
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    if (i_upd_valid) begin
      if (upd_hit) begin
        cnt_d[upd_idx] = upd_cnt_next;
        if (i_upd_taken) tgt_d[upd_idx] = i_upd_target;
      end else if (i_upd_taken) begin
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_tag;
        cnt_d[upd_idx]   = CNT_ALLOC;
        tgt_d[upd_idx]   = i_upd_target;
      end
    end
  end

  // Saturating statistics counters
  always_comb begin
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    if (i_upd_valid && (branches_q != 32'hFFFF_FFFF)) branches_d = branches_q + 32'd1;
    if (o_mispredict && (mispredicts_q != 32'hFFFF_FFFF)) mispredicts_d = mispredicts_q + 32'd1;
  end

  // Table and statistics registers, cleared asynchronously by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= CNT_RESET;
        tgt_q[i]   <= '0;
      end
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      cnt_q         <= cnt_d;
      tgt_q         <= tgt_d;
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a table model.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] recover_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_fetch_pc         (fetch_pc),
    .o_pred_taken       (pred_taken),
    .o_next_pc          (next_pc),
    .i_upd_valid        (upd_valid),
    .i_upd_pc           (upd_pc),
    .i_upd_taken        (upd_taken),
    .i_upd_target       (upd_target),
    .i_upd_pred_taken   (upd_pred_taken),
    .i_upd_pred_target  (upd_pred_target),
    .o_mispredict       (mispredict),
    .o_recover_pc       (recover_pc),
    .o_stat_branches    (stat_branches),
    .o_stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 16 entries indexed by word address modulo 16
  bit        mValid [16];
  bit [31:0] mTag   [16];
  int        mCnt   [16];
  bit [31:0] mTgt   [16];
  bit [31:0] mBranches;
  bit [31:0] mMispredicts;

  function automatic void modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0;
      mTag[i]   = 32'd0;
      mCnt[i]   = 1;
      mTgt[i]   = 32'd0;
    end
    mBranches    = 32'd0;
    mMispredicts = 32'd0;
  endfunction

  function automatic void modelPredict(input bit [31:0] pc, output bit pt, output bit [31:0] npc);
    int idx;
    idx = int'((pc / 4) % 16);
    pt  = mValid[idx] && (mTag[idx] == (pc / 64)) && (mCnt[idx] >= 2);
    npc = pt ? mTgt[idx] : pc + 32'd4;
  endfunction

  function automatic bit modelMispredict();
    if (!upd_valid) return 1'b0;
    if (upd_taken != upd_pred_taken) return 1'b1;
    return upd_taken && (upd_pred_target != upd_target);
  endfunction

  // Model state advances on the same edges as the DUT; reset clears it at once
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelReset();
    end else if (upd_valid) begin
      int idx;
      bit hit;
      idx = int'((upd_pc / 4) % 16);
      hit = mValid[idx] && (mTag[idx] == (upd_pc / 64));
      if (modelMispredict() && mMispredicts != 32'hFFFF_FFFF) mMispredicts = mMispredicts + 1;
      if (mBranches != 32'hFFFF_FFFF) mBranches = mBranches + 1;
      if (hit) begin
        if (upd_taken) begin
          mCnt[idx] = (mCnt[idx] == 3) ? 3 : mCnt[idx] + 1;
          mTgt[idx] = upd_target;
        end else begin
          mCnt[idx] = (mCnt[idx] == 0) ? 0 : mCnt[idx] - 1;
        end
      end else if (upd_taken) begin
        mValid[idx] = 1'b1;
        mTag[idx]   = upd_pc / 64;
        mCnt[idx]   = 2;
        mTgt[idx]   = upd_target;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge
  bit        cmpPred;
  bit [31:0] cmpNext;
  always @(negedge clk) begin
    modelPredict(fetch_pc, cmpPred, cmpNext);
    checkOutput("model_pred_taken", {31'd0, pred_taken}, {31'd0, cmpPred});
    checkOutput("model_next_pc", next_pc, cmpNext);
    if (upd_valid) begin
      checkOutput("model_mispredict", {31'd0, mispredict}, {31'd0, modelMispredict()});
      checkOutput("model_recover_pc", recover_pc, upd_taken ? upd_target : upd_pc + 32'd4);
    end
    checkOutput("model_stat_branches", stat_branches, mBranches);
    checkOutput("model_stat_mispredicts", stat_mispredicts, mMispredicts);
  end

  task automatic applyStimulus(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utgt,
                               input logic upt, input logic [31:0] uptgt);
    @(posedge clk);
    #1;
    fetch_pc        = fpc;
    upd_valid       = uv;
    upd_pc          = upc;
    upd_taken       = ut;
    upd_target      = utgt;
    upd_pred_taken  = upt;
    upd_pred_target = uptgt;
  endtask

  task automatic idle(input logic [31:0] fpc);
    applyStimulus(fpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_0050;

  initial begin
    bit        rp;
    bit [31:0] rn;
    logic [31:0] rfpc, rupc, rtgt;
    logic ruv, rut;

    modelReset();
    rst = 1'b1;
    fetch_pc = 32'd0; upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0;
    upd_target = 32'd0; upd_pred_taken = 1'b0; upd_pred_target = 32'd0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Reset state
    idle(PA);
    @(negedge clk);
    checkOutput("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("reset_next_pc", next_pc, 32'h0040_0014);
    checkOutput("reset_stat_branches", stat_branches, 32'd0);
    checkOutput("reset_stat_mispredicts", stat_mispredicts, 32'd0);

    // First taken branch allocates the entry
    applyStimulus(PA, 1'b1, PA, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    @(negedge clk);
    checkOutput("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    checkOutput("alloc_recover_pc", recover_pc, 32'h0040_0100);
    idle(PA);
    @(negedge clk);
    checkOutput("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
    checkOutput("alloc_next_pc", next_pc, 32'h0040_0100);
    checkOutput("alloc_stat_branches", stat_branches, 32'd1);
    checkOutput("alloc_stat_mispredicts", stat_mispredicts, 32'd1);

    // Three not-taken updates: 10 -> 01 -> 00 -> 00
    applyStimulus(PA, 1'b1, PA, 1'b0, 32'd0, 1'b1, 32'h0040_0100);
    @(negedge clk);
    checkOutput("nt1_mispredict", {31'd0, mispredict}, 32'd1);
    checkOutput("nt1_recover_pc", recover_pc, 32'h0040_0014);
    applyStimulus(PA, 1'b1, PA, 1'b0, 32'd0, 1'b0, 32'h0040_0014);
    @(negedge clk);
    checkOutput("nt2_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("nt2_mispredict", {31'd0, mispredict}, 32'd0);
    applyStimulus(PA, 1'b1, PA, 1'b0, 32'd0, 1'b0, 32'h0040_0014);
    @(negedge clk);
    checkOutput("nt3_pred_taken", {31'd0, pred_taken}, 32'd0);
    // Two taken updates must take 00 -> 01 -> 10, proving 00 did not wrap
    applyStimulus(PA, 1'b1, PA, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    @(negedge clk);
    checkOutput("sat_t1_pred_taken", {31'd0, pred_taken}, 32'd0);
    applyStimulus(PA, 1'b1, PA, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    @(negedge clk);
    checkOutput("sat_t2_pred_taken", {31'd0, pred_taken}, 32'd0);
    idle(PA);
    @(negedge clk);
    checkOutput("sat_after_pred_taken", {31'd0, pred_taken}, 32'd1);
    checkOutput("sat_stat_branches", stat_branches, 32'd6);
    checkOutput("sat_stat_mispredicts", stat_mispredicts, 32'd4);

    // Aliasing: PB shares index 4 with PA and evicts it
    applyStimulus(PA, 1'b1, PB, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0054);
    @(negedge clk);
    checkOutput("alias_mispredict", {31'd0, mispredict}, 32'd1);
    idle(PA);
    @(negedge clk);
    checkOutput("alias_old_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("alias_old_next_pc", next_pc, 32'h0040_0014);
    idle(PB);
    @(negedge clk);
    checkOutput("alias_new_pred_taken", {31'd0, pred_taken}, 32'd1);
    checkOutput("alias_new_next_pc", next_pc, 32'h0040_0200);

    // Same-cycle lookup and update on index 4: read before write
    applyStimulus(PB, 1'b1, PB, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0200);
    @(negedge clk);
    checkOutput("rbw_old_next_pc", next_pc, 32'h0040_0200);
    checkOutput("rbw_mispredict", {31'd0, mispredict}, 32'd1);
    checkOutput("rbw_recover_pc", recover_pc, 32'h0040_0300);
    idle(PB);
    @(negedge clk);
    checkOutput("rbw_new_next_pc", next_pc, 32'h0040_0300);

    // Asynchronous reset between edges, and an update presented during reset
    idle(PB);
    #1;
    checkOutput("arst_before_pred_taken", {31'd0, pred_taken}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("arst_next_pc", next_pc, 32'h0040_0054);
    checkOutput("arst_stat_branches", stat_branches, 32'd0);
    checkOutput("arst_stat_mispredicts", stat_mispredicts, 32'd0);
    applyStimulus(PB, 1'b1, PB, 1'b1, 32'h0040_0400, 1'b0, 32'h0040_0054);
    idle(PB);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("drop_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("drop_stat_branches", stat_branches, 32'd0);

    // Randomized traffic over 64 words so indices alias across four tags
    for (int n = 0; n < 600; n++) begin
      rfpc = 32'h0040_0000 + (32'($urandom_range(0, 63)) << 2);
      rupc = 32'h0040_0000 + (32'($urandom_range(0, 63)) << 2);
      rtgt = 32'h0040_1000 + (32'($urandom_range(0, 255)) << 2);
      ruv  = ($urandom_range(0, 3) != 0);
      rut  = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        modelPredict(rupc, rp, rn);
      end else begin
        rp = $urandom_range(0, 1);
        rn = rp ? rtgt : rupc + 32'd4;
      end
      applyStimulus(rfpc, ruv, rupc, rut, rtgt, rp, rn);
      if ((n % 200) == 150) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
      end
    end

    idle(32'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
